// File: rtl/tdm_mux_4x1_if.sv
// Bus interface for tdm_mux_4x1: parallel channel inputs, start/ready handshake,
// serialized word with channel tag, and status. The y_par signal exists only when
// TDM_PARITY_EN is defined.
interface tdm_mux_4x1_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] x3;
    logic         start;
    logic         ready;
    logic [W-1:0] y;
    logic         s1;
    logic         s0;
    logic         out_valid;
    logic         frame_start;
    logic         overrun;
    logic         clr_ovr;
`ifdef TDM_PARITY_EN
    logic         y_par;

    modport master (
        output x0, x1, x2, x3, start, clr_ovr,
        input  ready, y, s1, s0, out_valid, frame_start, overrun, y_par
    );
    modport slave (
        input  x0, x1, x2, x3, start, clr_ovr,
        output ready, y, s1, s0, out_valid, frame_start, overrun, y_par
    );
`else
    modport master (
        output x0, x1, x2, x3, start, clr_ovr,
        input  ready, y, s1, s0, out_valid, frame_start, overrun
    );
    modport slave (
        input  x0, x1, x2, x3, start, clr_ovr,
        output ready, y, s1, s0, out_valid, frame_start, overrun
    );
`endif
endinterface

// File: rtl/tdm_mux_4x1.sv
// Time-division 4:1 multiplexer. Captures x0..x3 on an accepted start and sends them
// one per clock on y with a 2-bit channel tag {s1,s0}. Optional parity output y_par
// is enabled by defining TDM_PARITY_EN.
module tdm_mux_4x1 #(
    parameter int unsigned W = 1
) (
    input logic          clk,
    input logic          rst_n,
    tdm_mux_4x1_if.slave bus
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e       state_q, state_d;
    logic [1:0]   ch_q, ch_d;
    logic [W-1:0] cap_q [4];

    logic         ready;
    logic         accept;
    logic         drop;
    logic [W-1:0] word_next;

    logic [W-1:0] y_d, y_q;
    logic [1:0]   tag_d, tag_q;
    logic         valid_d, valid_q;
    logic         fs_d, fs_q;
    logic         ovr_d, ovr_q;
    logic         par_d, par_q;

    // Ready is the only combinational output: idle, or on the last word of a frame.
    assign ready  = (state_q == StIdle) | ((state_q == StSend) & (ch_q == 2'd3));
    assign accept = bus.start & ready;
    assign drop   = bus.start & ~ready;

    // State register plus capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ch_q    <= 2'd0;
            for (int i = 0; i < 4; i++) cap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (accept) begin
                cap_q[0] <= bus.x0;
                cap_q[1] <= bus.x1;
                cap_q[2] <= bus.x2;
                cap_q[3] <= bus.x3;
            end
        end
    end

    // Next-state: walk ch 0..3, re-enter ch 0 directly on a back-to-back accept.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                ch_d = 2'd0;
                if (accept) state_d = StSend;
            end
            StSend: begin
                if (ch_q == 2'd3) begin
                    state_d = accept ? StSend : StIdle;
                    ch_d    = 2'd0;
                end else begin
                    ch_d = ch_q + 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
                ch_d    = 2'd0;
            end
        endcase
    end

    // Output next-values: the word shown next cycle comes straight from x0 on an
    // accept edge, since the capture registers load on that same edge.
    always_comb begin
        word_next = accept ? bus.x0 : cap_q[ch_d];
        valid_d   = (state_d == StSend);
        y_d       = valid_d ? word_next : '0;
        tag_d     = valid_d ? ch_d : 2'd0;
        fs_d      = valid_d & (ch_d == 2'd0);
        par_d     = valid_d & (^word_next);
        // A new drop wins over a simultaneous clear.
        ovr_d     = drop | (ovr_q & ~bus.clr_ovr);
    end

    // Registered outputs; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            tag_q   <= 2'd0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            ovr_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            ovr_q   <= ovr_d;
            par_q   <= par_d;
        end
    end

    assign bus.ready       = ready;
    assign bus.y           = y_q;
    assign bus.s1          = tag_q[1];
    assign bus.s0          = tag_q[0];
    assign bus.out_valid   = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.overrun     = ovr_q;
`ifdef TDM_PARITY_EN
    assign bus.y_par       = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Testbench for tdm_mux_4x1 (W=4): directed vector table, reset sequences, and
// randomized traffic checked against a queue-based frame model.
module tb_tdm_mux_4x1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    tdm_mux_4x1_if #(.W(4)) bus ();

    tdm_mux_4x1 #(.W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       clr;
        logic [3:0] x0, x1, x2, x3;
        logic       v;
        logic [3:0] y;
        logic [1:0] tag;
        logic       fs;
        logic       rdy;
        logic       ovr;
        logic       par;
    } vec_t;

    typedef struct {
        logic [3:0] w;
        logic [1:0] t;
    } item_t;

    vec_t  vec[$];
    item_t pend[$];
    logic       m_valid;
    logic [3:0] m_word;
    logic [1:0] m_tag;
    logic       m_ovr;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_out(input string tag_name, input logic v, input logic [3:0] y,
                             input logic [1:0] t, input logic fs, input logic rdy,
                             input logic ovr, input logic par);
        check({tag_name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag_name, ".y"}, 32'(bus.y), 32'(y));
        check({tag_name, ".tag"}, 32'({bus.s1, bus.s0}), 32'(t));
        check({tag_name, ".frame_start"}, 32'(bus.frame_start), 32'(fs));
        check({tag_name, ".ready"}, 32'(bus.ready), 32'(rdy));
        check({tag_name, ".overrun"}, 32'(bus.overrun), 32'(ovr));
`ifdef TDM_PARITY_EN
        check({tag_name, ".y_par"}, 32'(bus.y_par), 32'(par));
`else
        if (par === 1'bx) n_checks += 0;
`endif
    endtask

    task automatic row(input logic s, input logic c, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [3:0] e, input logic v,
                       input logic [3:0] y, input logic [1:0] t, input logic fs,
                       input logic rdy, input logic ovr, input logic par);
        vec_t r;
        r.start = s; r.clr = c; r.x0 = a; r.x1 = b; r.x2 = d; r.x3 = e;
        r.v = v; r.y = y; r.tag = t; r.fs = fs; r.rdy = rdy; r.ovr = ovr; r.par = par;
        vec.push_back(r);
    endtask

    task automatic drive(input logic s, input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d, input logic [3:0] e);
        bus.start = s; bus.clr_ovr = c; bus.x0 = a; bus.x1 = b; bus.x2 = d; bus.x3 = e;
    endtask

    // Reference model: pend holds the words still to be shown, cur is on the wire now.
    function automatic logic m_ready();
        return !m_valid || (pend.size() == 0);
    endfunction

    task automatic model_edge(input logic s, input logic c, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] d, input logic [3:0] e);
        logic rdy;
        item_t it;
        logic [3:0] xs [4];
        rdy = m_ready();
        xs[0] = a; xs[1] = b; xs[2] = d; xs[3] = e;
        if (s && rdy) begin
            for (int i = 0; i < 4; i++) begin
                it.w = xs[i];
                it.t = 2'(i);
                pend.push_back(it);
            end
        end
        m_ovr = (s && !rdy) ? 1'b1 : (c ? 1'b0 : m_ovr);
        if (pend.size() > 0) begin
            it = pend.pop_front();
            m_valid = 1'b1; m_word = it.w; m_tag = it.t;
        end else begin
            m_valid = 1'b0; m_word = 4'h0; m_tag = 2'd0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Directed table: inputs before an edge, expected outputs after it.
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,0,0);
        row(1,0, 4'h1,4'h2,4'h4,4'h8, 1,4'h1,0,1,0,0,1);
        row(0,0, 4'hF,4'hF,4'hF,4'hF, 1,4'h2,1,0,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h4,2,0,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h8,3,0,1,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,0,0);
        row(1,0, 4'h1,4'h2,4'h4,4'h8, 1,4'h1,0,1,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h2,1,0,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h4,2,0,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h8,3,0,1,0,1);
        row(1,0, 4'h9,4'hA,4'hB,4'hC, 1,4'h9,0,1,0,0,0);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'hA,1,0,0,0,0);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'hB,2,0,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'hC,3,0,1,0,0);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,0,0);
        row(1,0, 4'h1,4'h2,4'h4,4'h8, 1,4'h1,0,1,0,0,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h2,1,0,0,0,1);
        row(1,0, 4'h5,4'h5,4'h5,4'h5, 1,4'h4,2,0,0,1,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h8,3,0,1,1,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,1,0);
        row(0,1, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,0,0);
        row(1,0, 4'h3,4'h7,4'h0,4'hF, 1,4'h3,0,1,0,0,0);
        row(1,1, 4'h1,4'h1,4'h1,4'h1, 1,4'h7,1,0,0,1,1);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'h0,2,0,0,1,0);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 1,4'hF,3,0,1,1,0);
        row(0,0, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,1,0);
        row(0,1, 4'h0,4'h0,4'h0,4'h0, 0,4'h0,0,0,1,0,0);

        // Reset held for two cycles, then five idle cycles.
        repeat (2) begin
            @(negedge clk);
            check_out("in_reset", 0, 4'h0, 2'd0, 0, 1, 0, 0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_out("idle", 0, 4'h0, 2'd0, 0, 1, 0, 0);
        end

        foreach (vec[i]) begin
            @(negedge clk);
            drive(vec[i].start, vec[i].clr, vec[i].x0, vec[i].x1, vec[i].x2, vec[i].x3);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), vec[i].v, vec[i].y, vec[i].tag, vec[i].fs,
                      vec[i].rdy, vec[i].ovr, vec[i].par);
        end

        // Reset asserted while ch=2 is on the wire: outputs clear without a clock edge.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h1, 4'h2, 4'h4, 4'h8);
        @(posedge clk); #1;
        check_out("mid_ch0", 1, 4'h1, 2'd0, 1, 0, 0, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check_out("mid_ch2", 1, 4'h4, 2'd2, 0, 0, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 0, 4'h0, 2'd0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'h3, 4'h7, 4'h0, 4'hF);
        @(posedge clk); #1;
        check_out("post_rst0", 1, 4'h3, 2'd0, 1, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk); #1;
        check_out("post_rst1", 1, 4'h7, 2'd1, 0, 0, 0, 1);
        @(posedge clk); #1;
        check_out("post_rst2", 1, 4'h0, 2'd2, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_out("post_rst3", 1, 4'hF, 2'd3, 0, 1, 0, 0);
        @(posedge clk); #1;
        check_out("post_rst_idle", 0, 4'h0, 2'd0, 0, 1, 0, 0);

        // Randomized traffic against the frame model.
        m_valid = 1'b0; m_word = 4'h0; m_tag = 2'd0; m_ovr = 1'b0;
        pend.delete();
        for (int n = 0; n < 400; n++) begin
            logic s, c;
            logic [3:0] a, b, d, e;
            @(negedge clk);
            s = ($urandom_range(0, 9) < 5);
            c = ($urandom_range(0, 9) == 0);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            e = 4'($urandom_range(0, 15));
            drive(s, c, a, b, d, e);
            #1;
            check("rnd.ready_pre", 32'(bus.ready), 32'(m_ready()));
            @(posedge clk);
            model_edge(s, c, a, b, d, e);
            #1;
            check_out("rnd", m_valid, m_word, m_tag, m_valid && (m_tag == 2'd0),
                      m_ready(), m_ovr, m_valid && (^m_word));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
